// File: rtl/zrtc_glyph_fetch.sv
// zrtc_glyph_fetch: raster reader for the RTC time string on the TFT43 panel.
// Scans row -> char -> byte -> bit over eight 16x18 glyphs (2 bytes per row)
// fetched from a synchronous font ROM, and streams RGB565 pixels over
// valid/ready.
// Optional feature: define ZRTC_GLYPH_BLINK_EN to blank the colon glyphs
// (positions 2 and 5) while colon_blank is high.
//
// Handshake: a beat transfers on a rising edge where pix_valid & pix_ready.
// pix_valid never drops and pix_data/pix_eol/pix_eof never change while a
// beat is offered and not yet accepted.
module zrtc_glyph_fetch #(
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        colon_blank,
  output logic        busy,
  output logic        done,
  output logic [3:0]  char_sel,
  input  logic [10:0] glyph_base,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_FETCH = 3'd2,
    S_LOAD  = 3'd3,
    S_SHIFT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [2:0]  chr_q, chr_d;
  logic        byte_q, byte_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [10:0] addr_q, addr_d;
  logic        done_q, done_d;
  logic        blank_q, blank_d;

  logic beat_fire;
  logic byte_end;
  logic frame_end;

  // A beat leaves on this edge; the last beat of a byte/frame ends the scan step
  assign beat_fire = (state_q == S_SHIFT) && pix_ready;
  assign byte_end  = beat_fire && (bit_q == 3'd0);
  assign frame_end = byte_end && byte_q && (chr_q == 3'd7) && (row_q == 5'd17);

`ifndef ZRTC_GLYPH_BLINK_EN
  // colon_blank has no effect without the blink feature
  logic colon_blank_unused;
  assign colon_blank_unused = colon_blank;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= 5'd0;
      chr_q   <= 3'd0;
      byte_q  <= 1'b0;
      bit_q   <= 3'd7;
      shift_q <= 8'd0;
      addr_q  <= 11'd0;
      done_q  <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      chr_q   <= chr_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      blank_q <= blank_d;
    end
  end

  // Next FSM state; a start coinciding with done is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !done_q) state_d = S_ADDR;
      S_ADDR:  state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (byte_end) state_d = frame_end ? S_IDLE : S_ADDR;
      default: state_d = S_IDLE;
    endcase
  end

  // Next counters, ROM address and shift register contents
  always_comb begin
    row_d   = row_q;
    chr_d   = chr_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    blank_d = blank_q;
    done_d  = frame_end;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          row_d  = 5'd0;
          chr_d  = 3'd0;
          byte_d = 1'b0;
          bit_d  = 3'd7;
        end
      end
      S_ADDR: begin
        // 11-bit sum wraps naturally
        addr_d = glyph_base + {5'd0, row_q, 1'b0} + {10'd0, byte_q};
      end
      S_LOAD: begin
        shift_d = rom_data;
`ifdef ZRTC_GLYPH_BLINK_EN
        blank_d = colon_blank && ((chr_q == 3'd2) || (chr_q == 3'd5));
`else
        blank_d = 1'b0;
`endif
      end
      S_SHIFT: begin
        if (beat_fire) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q - 3'd1;
          if (bit_q == 3'd0) begin
            bit_d  = 3'd7;
            byte_d = ~byte_q;
            if (byte_q) begin
              chr_d = chr_q + 3'd1;
              if (chr_q == 3'd7) row_d = (row_q == 5'd17) ? 5'd0 : row_q + 5'd1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = done_q;
    char_sel  = {1'b0, chr_q};
    rom_addr  = addr_q;
    dbg_state = state_q;
    pix_valid = (state_q == S_SHIFT);
    pix_data  = 16'h0000;
    if (pix_valid) pix_data = (shift_q[7] && !blank_q) ? FG_COLOR : BG_COLOR;
    pix_eol   = pix_valid && (chr_q == 3'd7) && byte_q && (bit_q == 3'd0);
    pix_eof   = pix_eol && (row_q == 5'd17);
  end

endmodule
